// File: rtl/i2s_mic_ctrl.sv
// i2s_mic_ctrl: I2S master clocking, mic warm-up/run/drain sequencing and a one-entry sample holding register.
// Rev 1.0
`default_nettype none

module i2s_mic_ctrl #(
    parameter int BCLK_DIV      = 16,
    parameter int SLOT_BITS     = 32,
    parameter int WARMUP_FRAMES = 4096
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        enable,
    output logic        bclk,
    output logic        lrclk,
    input  logic [15:0] in_sample,
    input  logic        in_valid,
    output logic [15:0] out_sample,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        running,
    output logic        busy,
    output logic        overrun
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int BIT_W = $clog2(2 * SLOT_BITS);
    localparam int FRM_W = $clog2(WARMUP_FRAMES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(SLOT_BITS);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(WARMUP_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             bclk_q, bclk_d;
    logic             lrclk_q, lrclk_d;
    logic [15:0]      out_sample_q, out_sample_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;

    logic             fall_edge;
    logic             frame_end;
    logic             accept;

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            bclk_q       <= 1'b0;
            lrclk_q      <= 1'b0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            bclk_q       <= bclk_d;
            lrclk_q      <= lrclk_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        div_cnt_d    = '0;
        bit_cnt_d    = '0;
        bclk_d       = 1'b0;
        lrclk_d      = 1'b0;
        out_sample_d = out_sample_q;
        out_valid_d  = out_valid_q;
        overrun_d    = overrun_q;

        fall_edge = (div_cnt_q == DIV_LAST);
        frame_end = fall_edge && (bit_cnt_q == BIT_LAST);
        accept    = (state_q == S_RUN) || (state_q == S_DRAIN);

        case (state_q)
            S_IDLE: begin
                frame_cnt_d = '0;
                if (enable) begin
                    state_d   = S_WARMUP;
                    overrun_d = 1'b0;
                end
            end
            S_WARMUP: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (frame_end) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    if (frame_cnt_q == FRM_LAST) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (!enable) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (enable) begin
                    state_d = S_RUN;
                end else if (frame_end) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Counters are zero on both sides of IDLE so clocks restart phase-aligned.
        if ((state_q != S_IDLE) && (state_d != S_IDLE)) begin
            div_cnt_d = fall_edge ? '0 : div_cnt_q + 1'b1;
            bit_cnt_d = bit_cnt_q;
            if (fall_edge) begin
                bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
            end
            bclk_d  = (div_cnt_d >= DIV_HALF);
            lrclk_d = (bit_cnt_d >= BIT_HALF);
        end

        if (accept && in_valid) begin
            if (!out_valid_q || out_ready) begin
                out_sample_d = in_sample;
                out_valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign bclk       = bclk_q;
    assign lrclk      = lrclk_q;
    assign out_sample = out_sample_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;
    assign running    = (state_q == S_RUN);
    assign busy       = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_i2s_mic_ctrl.sv
// tb_i2s_mic_ctrl: self-checking bench for i2s_mic_ctrl with BCLK_DIV=4, SLOT_BITS=32, WARMUP_FRAMES=2.
// Rev 1.0
`default_nettype none

module tb_i2s_mic_ctrl;

    localparam int BCLK_DIV      = 4;
    localparam int SLOT_BITS     = 32;
    localparam int WARMUP_FRAMES = 2;
    localparam int FRAME_CYC     = BCLK_DIV * 2 * SLOT_BITS;
    localparam int WARM_CYC      = FRAME_CYC * WARMUP_FRAMES;

    logic        mclk = 1'b0;
    logic        rst;
    logic        enable;
    logic        bclk;
    logic        lrclk;
    logic [15:0] in_sample;
    logic        in_valid;
    logic [15:0] out_sample;
    logic        out_valid;
    logic        out_ready;
    logic        running;
    logic        busy;
    logic        overrun;

    i2s_mic_ctrl #(
        .BCLK_DIV      (BCLK_DIV),
        .SLOT_BITS     (SLOT_BITS),
        .WARMUP_FRAMES (WARMUP_FRAMES)
    ) dut (
        .mclk       (mclk),
        .rst        (rst),
        .enable     (enable),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .in_sample  (in_sample),
        .in_valid   (in_valid),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .running    (running),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic        iv;
        logic [15:0] s;
        logic        rdy;
        logic        ev;
        logic [15:0] es;
        logic        eo;
    } vec_t;

    vec_t        tbl [8];
    int          total = 0;
    int          bad   = 0;
    int          t     = 0;
    logic [15:0] sb_q [$];
    logic        mv    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%h want=%h", name, t, act, exp);
        end
    endtask

    // Handshakes are scored against the queue just before the edge that completes them.
    task automatic tick();
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow t=%0d got=%h want=<none>", t, out_sample);
            end else begin
                chk("sb_data", 32'(out_sample), 32'(sb_q.pop_front()));
            end
        end
        @(posedge mclk);
        #1;
        t++;
    endtask

    task automatic drive(input logic iv, input logic [15:0] s, input logic rdy, input logic acc);
        in_valid  = iv;
        in_sample = s;
        out_ready = rdy;
        if (acc && iv) begin
            if (!mv || rdy) begin
                sb_q.push_back(s);
                mv = 1'b1;
            end
        end else if (mv && rdy) begin
            mv = 1'b0;
        end
        tick();
    endtask

    function automatic logic exp_bclk(input int tt);
        return (tt % BCLK_DIV) >= (BCLK_DIV / 2);
    endfunction

    function automatic logic exp_lr(input int tt);
        return ((tt / BCLK_DIV) % (2 * SLOT_BITS)) >= SLOT_BITS;
    endfunction

    // Caller has just left IDLE; checks the whole warm-up and RUN entry.
    task automatic warmup_check();
        t = 0;
        for (int k = 0; k < WARM_CYC; k++) begin
            chk("warmup_pins", 32'({bclk, lrclk, running, busy, overrun, out_valid}),
                32'({exp_bclk(t), exp_lr(t), 1'b0, 1'b1, 1'b0, mv}));
            if (k == 100) drive(1'b1, 16'h5A5A, 1'b0, 1'b0);
            else          drive(1'b0, 16'h0000, 1'b0, 1'b0);
        end
        chk("run_entry", 32'({bclk, lrclk, running, busy}), 32'({1'b0, 1'b0, 1'b1, 1'b1}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0d got=timeout want=finish", t);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 16'h1234, 1'b0, 1'b1, 16'h1234, 1'b0};
        tbl[1] = '{1'b1, 16'hABCD, 1'b0, 1'b1, 16'h1234, 1'b1};
        tbl[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b1};
        tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 1'b1};
        tbl[4] = '{1'b1, 16'h1111, 1'b1, 1'b1, 16'h1111, 1'b1};
        tbl[5] = '{1'b1, 16'h2222, 1'b1, 1'b1, 16'h2222, 1'b1};
        tbl[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h2222, 1'b1};
        tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h2222, 1'b1};

        rst       = 1'b1;
        enable    = 1'b1;
        in_valid  = 1'b1;
        in_sample = 16'hFFFF;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge mclk);
            #1;
            chk("reset_outs", 32'({bclk, lrclk, out_sample, out_valid, running, busy, overrun}), 32'd0);
        end
        rst = 1'b0;
        chk("release_outs", 32'({bclk, lrclk, out_sample, out_valid, running, busy, overrun}), 32'd0);
        drive(1'b1, 16'hFFFF, 1'b0, 1'b0);
        chk("busy_rise", 32'({busy, out_valid, overrun}), 32'({1'b1, 1'b0, 1'b0}));

        warmup_check();

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].iv, tbl[i].s, tbl[i].rdy, 1'b1);
            chk("hs_valid",   32'(out_valid),  32'(tbl[i].ev));
            chk("hs_sample",  32'(out_sample), 32'(tbl[i].es));
            chk("hs_overrun", 32'(overrun),    32'(tbl[i].eo));
        end

        // Drop enable with bit_cnt = 10, capturing one sample on the same edge.
        while ((t % FRAME_CYC) != 40) drive(1'b0, 16'h0000, 1'b0, 1'b1);
        enable = 1'b0;
        drive(1'b1, 16'h3333, 1'b0, 1'b1);
        chk("drain_entry", 32'({running, busy, out_valid, overrun}), 32'({1'b0, 1'b1, 1'b1, 1'b1}));
        chk("drain_sample", 32'(out_sample), 32'h3333);
        while ((t % FRAME_CYC) != 0) begin
            chk("drain_pins", 32'({bclk, lrclk, busy, running}), 32'({exp_bclk(t), exp_lr(t), 1'b1, 1'b0}));
            drive(1'b0, 16'h0000, 1'b0, 1'b1);
        end
        chk("idle_pins", 32'({bclk, lrclk, busy, running, out_valid, overrun}),
            32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}));
        chk("idle_hold", 32'(out_sample), 32'h3333);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("idle_accept", 32'(out_valid), 32'd0);

        enable = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        warmup_check();

        drive(1'b1, 16'hBEEF, 1'b0, 1'b1);
        drive(1'b1, 16'hCAFE, 1'b0, 1'b1);
        chk("pre_rst", 32'({out_valid, overrun, out_sample}), 32'({1'b1, 1'b1, 16'hBEEF}));
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        sb_q.delete();
        mv = 1'b0;
        chk("midrun_rst", 32'({bclk, lrclk, out_sample, out_valid, running, busy, overrun}), 32'd0);
        rst = 1'b0;

        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        t = 0;
        chk("rewarm_busy", 32'(busy), 32'd1);
        while (t < 30) drive(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("abort_pre", 32'({bclk, busy}), 32'({exp_bclk(t), 1'b1}));
        enable = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("abort_idle", 32'({busy, bclk, lrclk, running}), 32'd0);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
